// File: rtl/tl_pkg.sv
// TileLink-UL slave shared definitions: opcodes, FSM encoding, log2 helper.
// Latency: none (definitions only).
// Backpressure: not applicable.
package tl_pkg;

    // Channel A request opcodes
    localparam logic [2:0] TL_A_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_A_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_A_GET         = 3'd4;

    // Channel D response opcodes
    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    // Slave transaction FSM: accept, touch the SRAM, then hold the response
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Smallest r such that 2**r >= value; used for SRAM index widths
    function automatic int tl_log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tl_sram_mem.sv
// Synchronous single-port SRAM with per-byte write enables.
// Latency: read data registered, valid one cycle after an enabled read.
// Backpressure: none; rdata holds until the next enabled read.
module tl_sram_mem
    import tl_pkg::*;
#(
    parameter int MEM_DEPTH  = 256,
    parameter int DATA_WIDTH = 32,
    localparam int AW = tl_log2(MEM_DEPTH),
    localparam int BW = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [BW-1:0]         be,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Byte-masked write or whole-word registered read; contents are never reset
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BW; i++) begin
                    if (be[i]) begin
                        r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/tl_sram_slave.sv
// TileLink-UL slave terminating Get/PutFullData/PutPartialData in an on-chip SRAM.
// Latency: accept in cycle 0, SRAM access in cycle 1, d_valid in cycle 2 (one txn per 3 cycles).
// Backpressure: single outstanding txn; a_ready low until the D handshake, D fields held while d_ready low.
module tl_sram_slave
    import tl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MASK_WIDTH   = DATA_WIDTH / 8,
    parameter int SIZE_WIDTH   = 3,
    parameter int SRC_WIDTH    = 1,
    parameter int SINK_WIDTH   = 1,
    parameter int OPCODE_WIDTH = 3,
    parameter int PARAM_WIDTH  = 3,
    parameter int MEM_DEPTH    = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [OPCODE_WIDTH-1:0] a_opcode,
    input  logic [PARAM_WIDTH-1:0]  a_param,
    input  logic [SIZE_WIDTH-1:0]   a_size,
    input  logic [SRC_WIDTH-1:0]    a_source,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [MASK_WIDTH-1:0]   a_mask,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [OPCODE_WIDTH-1:0] d_opcode,
    output logic [PARAM_WIDTH-1:0]  d_param,
    output logic [SIZE_WIDTH-1:0]   d_size,
    output logic [SRC_WIDTH-1:0]    d_source,
    output logic [SINK_WIDTH-1:0]   d_sink,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_error
);

    localparam int IDX_W = tl_log2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);

    state_t                  r_state;
    logic                    r_a_ready;
    logic                    r_d_valid;
    logic [OPCODE_WIDTH-1:0] r_d_opcode;
    logic [SIZE_WIDTH-1:0]   r_d_size;
    logic [SRC_WIDTH-1:0]    r_d_source;
    logic                    r_d_error;
    logic                    r_rd_ok;

    // Request fields captured at accept
    logic [OPCODE_WIDTH-1:0] r_opcode;
    logic [SIZE_WIDTH-1:0]   r_size;
    logic [SRC_WIDTH-1:0]    r_source;
    logic [IDX_W-1:0]        r_index;
    logic [MASK_WIDTH-1:0]   r_mask;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_d_fire;
    logic [ADDR_WIDTH-1:0]   w_offset;
    logic                    w_is_get;
    logic                    w_is_put;
    logic                    w_bad_op;
    logic                    w_oversize;
    logic                    w_misaligned;
    logic                    w_out_of_range;
    logic                    w_req_err;
    logic                    w_mem_en;
    logic                    w_mem_we;
    logic                    w_last_get;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic                    w_unused;

    assign w_accept = a_valid && r_a_ready;
    assign w_d_fire = r_d_valid && d_ready;

    // Request decode and error classification
    assign w_offset       = a_address - BASE_ADDR;
    assign w_is_get       = (a_opcode == OPCODE_WIDTH'(TL_A_GET));
    assign w_is_put       = (a_opcode == OPCODE_WIDTH'(TL_A_PUT_FULL)) ||
                            (a_opcode == OPCODE_WIDTH'(TL_A_PUT_PARTIAL));
    assign w_bad_op       = !(w_is_get || w_is_put);
    assign w_oversize     = (a_size > SIZE_WIDTH'(2));
    assign w_out_of_range = (w_offset >= MEM_BYTES);
    assign w_req_err      = w_bad_op || w_oversize || w_misaligned || w_out_of_range;

    // Alignment depends on transfer size; oversize requests are flagged separately
    always_comb begin
        w_misaligned = 1'b0;
        case (a_size)
            SIZE_WIDTH'(1): w_misaligned = a_address[0];
            SIZE_WIDTH'(2): w_misaligned = |a_address[1:0];
            default:        w_misaligned = 1'b0;
        endcase
    end

    // A clean request always has a legal opcode, so only Get vs Put matters here
    assign w_last_get = (r_opcode == OPCODE_WIDTH'(TL_A_GET));
    assign w_mem_en   = (r_state == ST_ACCESS) && !r_err;
    assign w_mem_we   = !w_last_get;

    tl_sram_mem #(
        .MEM_DEPTH  (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .en    (w_mem_en),
        .we    (w_mem_we),
        .be    (r_mask),
        .addr  (r_index),
        .wdata (r_wdata),
        .rdata (w_rdata)
    );

    // Transaction FSM with registered handshake and response fields
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_a_ready  <= 1'b0;
            r_d_valid  <= 1'b0;
            r_d_opcode <= '0;
            r_d_size   <= '0;
            r_d_source <= '0;
            r_d_error  <= 1'b0;
            r_rd_ok    <= 1'b0;
            r_opcode   <= '0;
            r_size     <= '0;
            r_source   <= '0;
            r_index    <= '0;
            r_mask     <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= ST_ACCESS;
                        r_a_ready <= 1'b0;
                        r_opcode  <= a_opcode;
                        r_size    <= a_size;
                        r_source  <= a_source;
                        r_index   <= w_offset[IDX_W+1:2];
                        r_mask    <= a_mask;
                        r_wdata   <= a_data;
                        r_err     <= w_req_err;
                    end else begin
                        r_a_ready <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    r_state    <= ST_RESP;
                    r_d_valid  <= 1'b1;
                    r_d_opcode <= w_last_get ? OPCODE_WIDTH'(TL_D_ACCESS_ACK_DATA)
                                             : OPCODE_WIDTH'(TL_D_ACCESS_ACK);
                    r_d_size   <= r_size;
                    r_d_source <= r_source;
                    r_d_error  <= r_err;
                    r_rd_ok    <= w_last_get && !r_err;
                end
                ST_RESP: begin
                    if (w_d_fire) begin
                        r_state    <= ST_IDLE;
                        r_a_ready  <= 1'b1;
                        r_d_valid  <= 1'b0;
                        r_d_opcode <= '0;
                        r_d_size   <= '0;
                        r_d_source <= '0;
                        r_d_error  <= 1'b0;
                        r_rd_ok    <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_a_ready <= 1'b0;
                    r_d_valid <= 1'b0;
                end
            endcase
        end
    end

    // The SRAM output register is the read-data register; it is only exposed for a good Get
    assign d_data   = r_rd_ok ? w_rdata : '0;
    assign a_ready  = r_a_ready;
    assign d_valid  = r_d_valid;
    assign d_opcode = r_d_opcode;
    assign d_size   = r_d_size;
    assign d_source = r_d_source;
    assign d_error  = r_d_error;
    assign d_param  = '0;
    assign d_sink   = '0;

    // Param field carries no meaning for these opcodes
    assign w_unused = ^a_param;

endmodule

// File: doc/tl_sram_slave.md
# tl_sram_slave

TileLink-UL slave that terminates Channel A requests in a single-port on-chip SRAM and returns Channel D responses. It sits downstream of `xbar_main`, on the slave side of the CDC adapter, in the slave clock domain. It handles one outstanding transaction: Get, PutFullData and PutPartialData. Out-of-range, misaligned, oversize and unsupported requests complete with `d_error`.

## Interface
- `ADDR_WIDTH`, 32: A-channel address width.
- `DATA_WIDTH`, 32: data width; only 32 is supported.
- `MASK_WIDTH`, `DATA_WIDTH/8`: byte-lane mask width.
- `SIZE_WIDTH`, 3: log2 of transfer bytes.
- `SRC_WIDTH`, 1: source ID width.
- `SINK_WIDTH`, 1: sink ID width.
- `OPCODE_WIDTH`, 3: opcode width.
- `PARAM_WIDTH`, 3: param width.
- `MEM_DEPTH`, 256: SRAM depth in words; power of two.
- `BASE_ADDR`, 32'h0000_0000: byte base address; aligned to `MEM_DEPTH*4`.
- `clk  in  1`: the single clock; all logic is on its rising edge.
- `reset  in  1`: asynchronous, active-low reset (0 = in reset).
- `a_valid  in  1`, `a_ready  out  1`: Channel A handshake.
- `a_opcode  in  OPCODE_WIDTH`: request opcode.
- `a_param  in  PARAM_WIDTH`: request param.
- `a_size  in  SIZE_WIDTH`: request size.
- `a_source  in  SRC_WIDTH`: request source ID.
- `a_address  in  ADDR_WIDTH`: request byte address.
- `a_mask  in  MASK_WIDTH`: request byte mask.
- `a_data  in  DATA_WIDTH`: request write data.
- `d_valid  out  1`, `d_ready  in  1`: Channel D handshake.
- `d_opcode  out  OPCODE_WIDTH`: response opcode.
- `d_param  out  PARAM_WIDTH`: response param.
- `d_size  out  SIZE_WIDTH`: response size.
- `d_source  out  SRC_WIDTH`: response source ID.
- `d_sink  out  SINK_WIDTH`: response sink ID.
- `d_data  out  DATA_WIDTH`: response read data.
- `d_error  out  1`: response error flag.

## Operation
- Opcodes.
  - A channel: PutFullData=0, PutPartialData=1, Get=4.
  - D channel: AccessAck=0, AccessAckData=1.
- FSM states are IDLE, ACCESS and RESP.
  - IDLE → ACCESS on `a_valid && a_ready`.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE on `d_valid && d_ready`.
- On accept, these fields are latched: opcode, size, source, word index, mask, data and error flag.
- The error flag is set when any of these holds:
  - the opcode is not 0, 1 or 4;
  - `a_size > 2`;
  - the address is misaligned for `a_size`;
  - `a_address - BASE_ADDR >= MEM_DEPTH*4` (unsigned).
- Memory access in ACCESS, only when there is no error:
  - Get: issue an SRAM read of the word.
  - Put: write the bytes where `a_mask` is set; other bytes are unchanged.
  - PutFullData and PutPartialData behave identically.
- Response in RESP:
  - `d_opcode` = AccessAckData for Get, AccessAck otherwise (including unsupported opcodes).
  - `d_size` and `d_source` echo the request.
  - `d_param` = 0 and `d_sink` = 0.
  - `d_data` = SRAM read word for a good Get, 0 otherwise.
  - `d_error` = the latched error flag.
- `a_param` is ignored.
- Reads return the whole word; masking is the master's job.

## Timing
- Reset values: `a_ready`=0, `d_valid`=0, all other `d_*` outputs = 0, state = IDLE. SRAM contents are not reset.
- `a_ready` is registered.
  - It is 1 only in IDLE.
  - It first rises in the first cycle after reset deasserts.
  - It falls in the cycle after an accept.
- Latency: an accept in cycle 0 gives ACCESS in cycle 1 and `d_valid`=1 in cycle 2.
- Throughput: at most one transaction every 3 cycles.
- `d_valid` and all `d_*` fields are registered and hold stable until `d_ready`.
- `d_valid` deasserts in the cycle after the D handshake; `a_ready` rises in that same cycle.
- `d_ready` low for N cycles stretches RESP by N cycles. No new A request is accepted meanwhile.
- `d_ready` held high before `d_valid` has no effect.
- Reset asserted mid-transaction aborts it immediately: outputs go to their reset values and no D response is produced.
  - A write already issued in ACCESS is kept.
  - A write that was not yet issued is dropped.
- Address arithmetic is `ADDR_WIDTH`-bit unsigned. The word index is `(a_address - BASE_ADDR) >> 2`, truncated to log2(`MEM_DEPTH`) bits.

## Structure
- Package `tl_pkg` holds:
  - the A and D opcode localparams;
  - the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - the log2 helper function.
- Sub-module `tl_sram_mem` is a synchronous single-port SRAM:
  - parameters `MEM_DEPTH` and `DATA_WIDTH`;
  - ports `en`, `we`, `be`, `addr`, `wdata`, `rdata`;
  - one-cycle read latency.
- `tl_sram_slave` contains the FSM, request decode and error check, and the D output registers.

## Test plan
- Put then read back:
  - PutFullData to 0x10, mask 4'hF, data 0xDEADBEEF → AccessAck with `d_error`=0, `d_valid` two cycles after accept.
  - Then Get 0x10, size 2 → AccessAckData with `d_data`=0xDEADBEEF.
- PutPartialData to 0x10, mask 4'b0011, data 0x0000CAFE, then Get 0x10 → `d_data`=0xDEADCAFE.
- Each of these returns `d_error`=1, `d_data`=0 and leaves memory unchanged:
  - Get at 0x400 (out of range);
  - Get at 0x11 with size 2 (misaligned);
  - opcode 3, which returns AccessAck.
- Hold `d_ready`=0 for 5 cycles on a Get response:
  - `d_valid` and the `d_*` fields stay stable;
  - `a_ready` stays 0 while `a_valid` is asserted;
  - the response completes on the cycle `d_ready` rises.
- Assert reset in the ACCESS cycle of a Get:
  - `d_valid` and `a_ready` go to 0 immediately;
  - no response after release;
  - `a_ready`=1 in the first cycle after release.
- Back-to-back Gets with `a_valid` and `d_ready` held high give one transaction every 3 cycles, with `d_source` echoed correctly each time.
